// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Start/done handshake; divide-by-zero short-circuits straight to DONE.
//
//   state | meaning
//   IDLE  | waiting for start; result registers hold the last result
//   CALC  | shift-and-trial-subtract, count down from W to terminal count
//   DONE  | one-cycle done pulse, results valid
module seq_divider #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  r_q, r_d;
  logic [W-1:0]  q_q, q_d;
  logic [W-1:0]  d_q, d_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dbz_q, dbz_d;
  logic [W-1:0]  r_sh;
  logic [W:0]    trial;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    // Partial remainder never has its MSB set before a shift, so dropping it is lossless.
    r_sh    = {r_q[W-2:0], q_q[W-1]};
    trial   = {1'b0, r_sh} - {1'b0, d_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          dbz_d = 1'b0;
          d_d   = divisor;
          if (divisor == '0) begin
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            r_d     = '0;
            q_d     = dividend;
            cnt_d   = CW'(W);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        q_d   = {q_q[W-2:0], ~trial[W]};
        r_d   = trial[W] ? r_sh : trial[W-1:0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          quo_d   = q_d;
          rem_d   = r_d;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (W=4): handshake timing, zero divisor,
// ignored restart, mid-operation reset and an exhaustive operand sweep.
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_divider #(.W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one operation and checks latency (edges counted from the accepting edge),
  // results, and that done is exactly one cycle wide.
  task automatic run_div(input logic [3:0] a, input logic [3:0] b, input int exp_lat,
                         input logic [3:0] eq, input logic [3:0] er, input logic edbz);
    int edges;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("busy_after_start %0d/%0d", a, b), 16'(busy), 16'd1);
    while (!done && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk($sformatf("latency %0d/%0d", a, b), 16'(edges), 16'(exp_lat));
    chk($sformatf("quotient %0d/%0d", a, b), 16'(quotient), 16'(eq));
    chk($sformatf("remainder %0d/%0d", a, b), 16'(remainder), 16'(er));
    chk($sformatf("dbz %0d/%0d", a, b), 16'(div_by_zero), 16'(edbz));
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("done_width %0d/%0d", a, b), 16'(done), 16'd0);
    chk($sformatf("busy_idle %0d/%0d", a, b), 16'(busy), 16'd0);
  endtask

  initial begin
    int edges;
    int done_cnt;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #1;
    chk("reset_quotient", 16'(quotient), 16'd0);
    chk("reset_remainder", 16'(remainder), 16'd0);
    chk("reset_busy", 16'(busy), 16'd0);
    chk("reset_done", 16'(done), 16'd0);
    chk("reset_dbz", 16'(div_by_zero), 16'd0);
    @(negedge clk);
    rst = 1'b0;

    run_div(4'd13, 4'd3, 5, 4'd4, 4'd1, 1'b0);
    run_div(4'd15, 4'd1, 5, 4'd15, 4'd0, 1'b0);
    run_div(4'd2, 4'd9, 5, 4'd0, 4'd2, 1'b0);
    run_div(4'd0, 4'd5, 5, 4'd0, 4'd0, 1'b0);
    run_div(4'd7, 4'd0, 1, 4'hF, 4'd7, 1'b1);
    run_div(4'd8, 4'd2, 5, 4'd4, 4'd0, 1'b0);

    // 9/2 with a second start (15/15) during CALC that must be ignored.
    @(negedge clk);
    dividend = 4'd9;
    divisor  = 4'd2;
    start    = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    edges++;
    @(negedge clk);
    chk("hold_quotient_in_calc", 16'(quotient), 16'd4);
    chk("hold_remainder_in_calc", 16'(remainder), 16'd0);
    dividend = 4'd15;
    divisor  = 4'd15;
    start    = 1'b1;
    @(posedge clk);
    edges++;
    @(negedge clk);
    start = 1'b0;
    while (!done && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk("restart_latency", 16'(edges), 16'd5);
    chk("restart_quotient", 16'(quotient), 16'd4);
    chk("restart_remainder", 16'(remainder), 16'd1);
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("restart_single_done", 16'(done_cnt), 16'd0);
    chk("hold_quotient_idle", 16'(quotient), 16'd4);

    // 12/5 aborted by reset during the second CALC cycle.
    @(negedge clk);
    dividend = 4'd12;
    divisor  = 4'd5;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", 16'(busy), 16'd0);
    chk("abort_done", 16'(done), 16'd0);
    chk("abort_quotient", 16'(quotient), 16'd0);
    chk("abort_remainder", 16'(remainder), 16'd0);
    chk("abort_dbz", 16'(div_by_zero), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    chk("abort_no_done", 16'(done_cnt), 16'd0);
    run_div(4'd12, 4'd5, 5, 4'd2, 4'd2, 1'b0);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0)
          run_div(4'(a), 4'(b), 1, 4'hF, 4'(a), 1'b1);
        else
          run_div(4'(a), 4'(b), 5, 4'(a / b), 4'(a % b), 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
